// File: rtl/apb_pkg.sv
// apb_pkg: shared FSM states, response encoding and strobe-width helper for the APB register file
package apb_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_t;
  typedef enum logic {OKAY = 1'b0, SLVERR = 1'b1} apb_resp_t;
  function automatic int strb_w(input int dw);
    return dw / 8;
  endfunction
endpackage

// File: rtl/apb_regfile_slave_if.sv
// apb_regfile_slave_if: APB4 bus between a master and the register-file completer
interface apb_regfile_slave_if
  import apb_pkg::*;
#(
  parameter int addrWidth = 8,
  parameter int dataWidth = 32
);
  logic                          psel;
  logic                          penable;
  logic                          pwrite;
  logic [addrWidth-1:0]          paddr;
  logic [dataWidth-1:0]          pwdata;
  logic [strb_w(dataWidth)-1:0]  pstrb;
  logic [dataWidth-1:0]          prdata;
  logic                          pready;
  logic                          pslverr;
  modport master(output psel, penable, pwrite, paddr, pwdata, pstrb, input prdata, pready, pslverr);
  modport slave(input psel, penable, pwrite, paddr, pwdata, pstrb, output prdata, pready, pslverr);
endinterface

// File: rtl/apb_regfile.sv
// apb_regfile: numRegs x dataWidth storage with one byte-strobed write port and one async read port
module apb_regfile
  import apb_pkg::*;
#(
  parameter int dataWidth = 32,
  parameter int numRegs   = 16,
  parameter int idxW      = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_we,
  input  logic [idxW-1:0]              i_widx,
  input  logic [dataWidth-1:0]         i_wdata,
  input  logic [strb_w(dataWidth)-1:0] i_wstrb,
  input  logic [idxW-1:0]              i_ridx,
  output logic [dataWidth-1:0]         o_rdata
);
  logic [dataWidth-1:0] r_mem [numRegs];
  // clear on reset; otherwise merge only the strobed bytes into the addressed register
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < numRegs; k++) r_mem[k] <= '0;
    end else if (i_we) begin
      for (int b = 0; b < strb_w(dataWidth); b++)
        if (i_wstrb[b]) r_mem[i_widx][8*b +: 8] <= i_wdata[8*b +: 8];
    end
  end
  assign o_rdata = r_mem[i_ridx];
endmodule

// File: rtl/apb_regfile_slave.sv
// apb_regfile_slave: APB4 completer with wait states and error response fronting a byte-strobed register file
module apb_regfile_slave
  import apb_pkg::*;
#(
  parameter int addrWidth  = 8,
  parameter int dataWidth  = 32,
  parameter int numRegs    = 16,
  parameter int waitStates = 0
) (
  input logic clk,
  input logic reset,
  apb_regfile_slave_if.slave bus
);
  localparam int B = $clog2(dataWidth / 8);
  localparam int IDX_W = numRegs > 1 ? $clog2(numRegs) : 1;
  localparam logic [addrWidth-1:0] MASK = addrWidth'((1 << B) - 1);
  apb_state_t                   r_state, w_next, w_phase;
  logic [3:0]                   r_cnt, w_cnt;
  logic [addrWidth-1:0]         r_addr, w_index;
  logic                         r_write;
  logic [dataWidth-1:0]         r_wdata, w_rdata;
  logic [strb_w(dataWidth)-1:0] r_strb;
  logic                         w_active, w_done, w_err, w_we, w_pready;
  apb_resp_t                    w_resp;
  // the setup phase is a request on the bus while no access is in flight; it is latched on its closing edge
  always_comb begin
    w_active = bus.psel && bus.penable;
    w_phase  = (r_state == ACCESS) ? ACCESS : ((bus.psel && !bus.penable) ? SETUP : IDLE);
    w_done   = (r_state == ACCESS) && w_active && (r_cnt == 4'd0);
    w_next   = ((w_phase == SETUP) || ((r_state == ACCESS) && w_active && (r_cnt != 4'd0))) ? ACCESS : IDLE;
    w_cnt    = (w_phase == SETUP) ? 4'(waitStates) :
               ((r_state == ACCESS) && w_active && (r_cnt != 4'd0)) ? r_cnt - 4'd1 : 4'd0;
  end
  // state, wait counter and latched request
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_write <= 1'b0;
      r_wdata <= '0;
      r_strb  <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt;
      if (w_phase == SETUP) begin
        r_addr  <= bus.paddr;
        r_write <= bus.pwrite;
        r_wdata <= bus.pwdata;
        r_strb  <= bus.pstrb;
      end
    end
  end
  assign w_index  = r_addr >> B;
  assign w_err    = (|(r_addr & MASK)) || (32'(w_index) >= numRegs);
  assign w_pready = (r_state == ACCESS) && (r_cnt == 4'd0);
  assign w_we     = w_done && r_write && !w_err;
  assign w_resp   = (w_pready && w_err) ? SLVERR : OKAY;
  apb_regfile #(.dataWidth(dataWidth), .numRegs(numRegs), .idxW(IDX_W)) u_regs (
    .clk    (clk),
    .reset  (reset),
    .i_we   (w_we),
    .i_widx (w_index[IDX_W-1:0]),
    .i_wdata(r_wdata),
    .i_wstrb(r_strb),
    .i_ridx (w_index[IDX_W-1:0]),
    .o_rdata(w_rdata)
  );
  assign bus.pready  = w_pready;
  assign bus.pslverr = w_resp == SLVERR;
  assign bus.prdata  = (w_pready && !w_err && !r_write) ? w_rdata : '0;
endmodule

// File: tb/tb_apb_regfile_slave.sv
// tb_apb_regfile_slave: table, corner-case and randomized checks of two completers (0 and 3 wait states)
module tb_apb_regfile_slave;
  logic        clk = 0, reset = 0;
  logic        psel = 0, penable = 0, pwrite = 0;
  logic [7:0]  paddr = 0;
  logic [31:0] pwdata = 0;
  logic [3:0]  pstrb = 0;
  int          sel = 0;
  logic        pready_o, pslverr_o;
  logic [31:0] prdata_o;
  int          checks = 0, failures = 0;
  logic [31:0] mem [2][16];
  always #5 clk = ~clk;
  apb_regfile_slave_if #(.addrWidth(8), .dataWidth(32)) bus0 ();
  apb_regfile_slave_if #(.addrWidth(8), .dataWidth(32)) bus3 ();
  assign bus0.psel = psel && sel == 0;
  assign bus0.penable = penable;
  assign bus0.pwrite = pwrite;
  assign bus0.paddr = paddr;
  assign bus0.pwdata = pwdata;
  assign bus0.pstrb = pstrb;
  assign bus3.psel = psel && sel == 1;
  assign bus3.penable = penable;
  assign bus3.pwrite = pwrite;
  assign bus3.paddr = paddr;
  assign bus3.pwdata = pwdata;
  assign bus3.pstrb = pstrb;
  assign pready_o  = sel != 0 ? bus3.pready : bus0.pready;
  assign pslverr_o = sel != 0 ? bus3.pslverr : bus0.pslverr;
  assign prdata_o  = sel != 0 ? bus3.prdata : bus0.prdata;
  apb_regfile_slave #(.addrWidth(8), .dataWidth(32), .numRegs(16), .waitStates(0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0));
  apb_regfile_slave #(.addrWidth(8), .dataWidth(32), .numRegs(16), .waitStates(3)) dut3 (
    .clk(clk), .reset(reset), .bus(bus3));

  typedef struct {
    logic        w;
    logic [7:0]  a;
    logic [31:0] d;
    logic [3:0]  s;
    logic [31:0] rd;
    logic        err;
  } vec_t;
  vec_t tbl [12];

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", n, got, exp);
    end
  endtask

  // reference: aligned word index below 16 is valid, writes merge strobed bytes
  task automatic model(input int s, input logic w, input logic [7:0] a, input logic [31:0] d,
                       input logic [3:0] st, output logic [31:0] rd, output logic err);
    int idx;
    idx = int'(a) / 4;
    err = (int'(a) % 4 != 0) || (idx >= 16);
    rd = 0;
    if (!err && w) for (int i = 0; i < 4; i++) if (st[i]) mem[s][idx][8*i +: 8] = d[8*i +: 8];
    if (!err && !w) rd = mem[s][idx];
  endtask

  task automatic clear_model();
    for (int s = 0; s < 2; s++) for (int i = 0; i < 16; i++) mem[s][i] = 0;
  endtask

  task automatic xfer(input logic w, input logic [7:0] a, input logic [31:0] d, input logic [3:0] st,
                      output logic [31:0] rd, output logic err, output int cyc);
    @(negedge clk);
    psel = 1; penable = 0; pwrite = w; paddr = a; pwdata = d; pstrb = st; cyc = 1;
    @(negedge clk);
    penable = 1; cyc = 2;
    while (!pready_o && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    rd = prdata_o;
    err = pslverr_o;
  endtask

  task automatic idle();
    @(negedge clk);
    psel = 0; penable = 0;
    chk("pready single cycle", 32'(pready_o), 0);
  endtask

  initial begin
    logic [31:0] rd, erd;
    logic        err, eerr;
    int          cyc, seen;
    logic [7:0]  a;
    clear_model();
    repeat (3) @(negedge clk);
    chk("reset pready0", 32'(bus0.pready), 0);
    chk("reset pslverr0", 32'(bus0.pslverr), 0);
    chk("reset prdata0", bus0.prdata, 0);
    chk("reset pready3", 32'(bus3.pready), 0);
    reset = 1;
    tbl[0]  = '{0, 8'h00, 32'h0, 4'h0, 32'h0, 0};
    tbl[1]  = '{1, 8'h04, 32'hDEADBEEF, 4'hF, 32'h0, 0};
    tbl[2]  = '{1, 8'h04, 32'h00000011, 4'h1, 32'h0, 0};
    tbl[3]  = '{0, 8'h04, 32'h0, 4'h0, 32'hDEADBE11, 0};
    tbl[4]  = '{0, 8'h40, 32'h0, 4'h0, 32'h0, 1};
    tbl[5]  = '{0, 8'h02, 32'h0, 4'h0, 32'h0, 1};
    tbl[6]  = '{1, 8'h40, 32'hFFFFFFFF, 4'hF, 32'h0, 1};
    tbl[7]  = '{1, 8'h05, 32'hFFFFFFFF, 4'hF, 32'h0, 1};
    tbl[8]  = '{0, 8'h00, 32'h0, 4'h0, 32'h0, 0};
    tbl[9]  = '{0, 8'h04, 32'h0, 4'h0, 32'hDEADBE11, 0};
    tbl[10] = '{1, 8'h3C, 32'h12345678, 4'hA, 32'h0, 0};
    tbl[11] = '{0, 8'h3C, 32'h0, 4'h0, 32'h12005600, 0};
    sel = 0;
    for (int i = 0; i < 12; i++) begin
      xfer(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].s, rd, err, cyc);
      model(0, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].s, erd, eerr);
      chk($sformatf("vec%0d prdata", i), rd, tbl[i].rd);
      chk($sformatf("vec%0d pslverr", i), 32'(err), 32'(tbl[i].err));
      chk($sformatf("vec%0d cycles", i), cyc, 2);
    end
    idle();
    sel = 1;
    xfer(1, 8'h08, 32'h12345678, 4'hF, rd, err, cyc);
    model(1, 1, 8'h08, 32'h12345678, 4'hF, erd, eerr);
    chk("ws3 write cycles", cyc, 5);
    chk("ws3 write pslverr", 32'(err), 0);
    idle();
    @(negedge clk);
    psel = 1; penable = 0; pwrite = 1; paddr = 8'h08; pwdata = 32'hA5A5A5A5; pstrb = 4'hF;
    @(negedge clk);
    penable = 1;
    chk("abort wait pready", 32'(pready_o), 0);
    @(negedge clk);
    psel = 0; penable = 0;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      seen = seen | int'(pready_o);
    end
    chk("abort no pready", seen, 0);
    xfer(0, 8'h08, 32'h0, 4'h0, rd, err, cyc);
    chk("abort reg kept", rd, 32'h12345678);
    chk("ws3 read cycles", cyc, 5);
    idle();
    sel = 0;
    @(negedge clk);
    psel = 1; penable = 0; pwrite = 1; paddr = 8'h0C; pwdata = 32'hCAFEF00D; pstrb = 4'hF;
    @(negedge clk);
    penable = 1;
    chk("pre-reset pready", 32'(pready_o), 1);
    reset = 0;
    @(negedge clk);
    chk("reset mid pready", 32'(pready_o), 0);
    chk("reset mid pslverr", 32'(pslverr_o), 0);
    chk("reset mid prdata", prdata_o, 0);
    reset = 1; psel = 0; penable = 0;
    clear_model();
    xfer(0, 8'h0C, 32'h0, 4'h0, rd, err, cyc);
    chk("reset discarded write", rd, 0);
    xfer(0, 8'h04, 32'h0, 4'h0, rd, err, cyc);
    chk("reset cleared reg1", rd, 0);
    idle();
    sel = 1;
    xfer(0, 8'h08, 32'h0, 4'h0, rd, err, cyc);
    chk("reset cleared ws3 reg2", rd, 0);
    idle();
    sel = 0;
    xfer(1, 8'h0C, 32'h11223344, 4'hF, rd, err, cyc);
    model(0, 1, 8'h0C, 32'h11223344, 4'hF, erd, eerr);
    xfer(0, 8'h0C, 32'h0, 4'h0, rd, err, cyc);
    chk("b2b read data", rd, 32'h11223344);
    chk("b2b read cycles", cyc, 2);
    idle();
    for (int n = 0; n < 300; n++) begin
      int r;
      logic w;
      logic [31:0] d;
      logic [3:0] st;
      r = int'($urandom_range(0, 9));
      a = r < 8 ? 8'($urandom_range(0, 15) * 4) :
          r == 8 ? 8'($urandom_range(0, 63) * 4 + $urandom_range(1, 3)) :
                   8'($urandom_range(16, 63) * 4);
      w = 1'($urandom_range(0, 1));
      d = $urandom;
      st = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) begin
        idle();
        sel = int'($urandom_range(0, 1));
      end
      model(sel, w, a, d, st, erd, eerr);
      xfer(w, a, d, st, rd, err, cyc);
      chk($sformatf("rand%0d prdata a=%h", n, a), rd, erd);
      chk($sformatf("rand%0d pslverr a=%h", n, a), 32'(err), 32'(eerr));
      chk($sformatf("rand%0d cycles", n), cyc, sel != 0 ? 5 : 2);
    end
    idle();
    for (int s = 0; s < 2; s++) begin
      sel = s;
      for (int i = 0; i < 16; i++) begin
        xfer(0, 8'(i * 4), 32'h0, 4'h0, rd, err, cyc);
        chk($sformatf("final dut%0d reg%0d", s, i), rd, mem[s][i]);
      end
      idle();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
